// File: rtl/accel_inbuf.sv
// accel_inbuf: input buffer between the AXI4 controller's to-accelerator
// stream and the ECDSA core. DEPTH-entry array plus one output register
// (OREG) so the core sees a fully registered valid/ready interface.
// rdptr reports consumed words (mod DEPTH) back to the controller.
//
// Optional build macro: ACCEL_INBUF_WATERMARK_EN adds parameter AF_LEVEL
// and a registered almost_full output.
module accel_inbuf #(
    parameter int DW    = 128,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
`ifdef ACCEL_INBUF_WATERMARK_EN
    ,
    parameter int AF_LEVEL = DEPTH - 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [AW-1:0] rdptr,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [AW:0]   level,
    output logic          overflow
`ifdef ACCEL_INBUF_WATERMARK_EN
    ,
    output logic          almost_full
`endif
);

    // Pointer arithmetic relies on DEPTH being exactly 2**AW.
    if (DEPTH != (1 << AW) || DEPTH < 4) begin : g_param_check
        $error("accel_inbuf: DEPTH must be a power of two >= 4 and equal 2**AW");
    end

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // Storage array; contents are never reset.
    logic [DW-1:0] mem [DEPTH];

    // Wrap-bit pointers: equal => array empty.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    // Words accepted but not yet consumed (array + OREG).
    logic [AW:0]   level_q, level_d;
    // Consumed-word count returned to the controller.
    logic [AW-1:0] rdptr_q, rdptr_d;
    // Output register and its valid.
    logic [DW-1:0] oreg_q, oreg_d;
    logic          ovld_q, ovld_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic          pop;
    logic          load;
    logic          arr_empty;

`ifdef ACCEL_INBUF_WATERMARK_EN
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
    logic          almost_full_q, almost_full_d;
`endif

    // Ready depends only on registered level; held low while reset is applied.
    assign s_tready  = ~rst & (level_q != FULL_LVL);

    assign push      = s_tvalid & s_tready;
    assign pop       = ovld_q & m_tready;
    assign arr_empty = (wr_ptr_q == rd_ptr_q);
    // OREG refills whenever it is empty or being drained this cycle.
    assign load      = (~ovld_q | m_tready) & ~arr_empty;

    // Next-state for pointers, level, output register and sticky flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rdptr_d    = rdptr_q;
        oreg_d     = oreg_q;
        ovld_d     = ovld_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (load) begin
            oreg_d   = mem[rd_ptr_q[AW-1:0]];
            ovld_d   = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (pop) begin
            ovld_d   = 1'b0;
        end

        if (pop) begin
            rdptr_d = rdptr_q + 1'b1;
        end

        // Simultaneous push and pop leaves level unchanged.
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (s_tvalid & ~s_tready) begin
            overflow_d = 1'b1;
        end

        // Flush discards everything but advances rdptr past the discarded
        // words so the controller's free-space count stays consistent.
        // level is at most DEPTH, which adds zero mod DEPTH.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            oreg_d     = '0;
            ovld_d     = 1'b0;
            overflow_d = 1'b0;
            rdptr_d    = rdptr_q + level_q[AW-1:0];
        end
    end

`ifdef ACCEL_INBUF_WATERMARK_EN
    // Watermark tracks the post-update level.
    always_comb begin
        almost_full_d = 1'b0;
        if (!flush) begin
            almost_full_d = (level_d >= AF_LVL);
        end
    end
`endif

    // State registers with synchronous reset (reset wins over flush).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rdptr_q    <= '0;
            oreg_q     <= '0;
            ovld_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rdptr_q    <= rdptr_d;
            oreg_q     <= oreg_d;
            ovld_q     <= ovld_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ACCEL_INBUF_WATERMARK_EN
    // Watermark register.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`endif

    // Array write; a flushed push is dropped so nothing stale is stored.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q[AW-1:0]] <= s_tdata;
        end
    end

    assign rdptr    = rdptr_q;
    assign m_tdata  = oreg_q;
    assign m_tvalid = ovld_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_accel_inbuf.sv
// Directed bench for accel_inbuf (default parameters DW=128, DEPTH=1024).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_accel_inbuf;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [9:0]   rdptr;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic [10:0]  level;
    logic         overflow;
`ifdef ACCEL_INBUF_WATERMARK_EN
    logic         almost_full;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    accel_inbuf dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .rdptr      (rdptr),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .level      (level),
        .overflow   (overflow)
`ifdef ACCEL_INBUF_WATERMARK_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [127:0] base);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = base + 128'(i);
            step();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 128'h55;
        step();
        step();
        n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready got %b want 0", s_tready); end
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
        n_chk++; if (m_tdata !== 128'h0) begin n_fail++; $display("FAIL reset_m_tdata got %h want 0", m_tdata); end
        n_chk++; if (level !== 11'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_chk++; if (rdptr !== 10'd0) begin n_fail++; $display("FAIL reset_rdptr got %0d want 0", rdptr); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        #1;
        n_chk++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_s_tready got %b want 1", s_tready); end
    endtask

    task automatic test_single();
        logic [127:0] w;
        w = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        do_reset();
        m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = w;
        step(); // edge N: push
        s_tvalid = 1'b0;
        n_chk++; if (level !== 11'd1 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_after_push level=%0d m_tvalid=%b want 1/0", level, m_tvalid); end
        step(); // edge N+1: OREG load
        n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== w) begin n_fail++; $display("FAIL single_out got v=%b d=%h want 1/%h", m_tvalid, m_tdata, w); end
        step(); // edge N+2: pop
        m_tready = 1'b0;
        n_chk++; if (level !== 11'd0 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drained level=%0d m_tvalid=%b want 0/0", level, m_tvalid); end
        n_chk++; if (rdptr !== 10'd1) begin n_fail++; $display("FAIL single_rdptr got %0d want 1", rdptr); end
    endtask

    task automatic test_fill();
        int bad;
        do_reset();
        push_n(1024, 128'h0);
        n_chk++; if (level !== 11'd1024) begin n_fail++; $display("FAIL fill_level got %0d want 1024", level); end
        n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL fill_s_tready got %b want 0", s_tready); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow got %b want 0", overflow); end
        s_tvalid = 1'b1; s_tdata = 128'hDEAD;
        step();
        s_tvalid = 1'b0;
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b want 1", overflow); end
        n_chk++; if (level !== 11'd1024) begin n_fail++; $display("FAIL fill_level_after_ovf got %0d want 1024", level); end
        m_tready = 1'b1;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            n_chk++;
            if (m_tvalid !== 1'b1 || m_tdata !== 128'(i)) begin
                n_fail++;
                if (bad < 5) $display("FAIL drain_word[%0d] got v=%b d=%h want 1/%h", i, m_tvalid, m_tdata, 128'(i));
                bad++;
            end
            step();
        end
        m_tready = 1'b0;
        n_chk++; if (m_tvalid !== 1'b0 || level !== 11'd0) begin n_fail++; $display("FAIL drain_empty v=%b level=%0d want 0/0", m_tvalid, level); end
        n_chk++; if (rdptr !== 10'd0) begin n_fail++; $display("FAIL drain_rdptr_wrap got %0d want 0", rdptr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_n(1023, 128'h100);
        n_chk++; if (level !== 11'd1023 || m_tvalid !== 1'b1 || m_tdata !== 128'h100) begin n_fail++; $display("FAIL bp_start level=%0d v=%b d=%h want 1023/1/100", level, m_tvalid, m_tdata); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== 128'h100) begin n_fail++; $display("FAIL bp_hold[%0d] v=%b d=%h want 1/100", i, m_tvalid, m_tdata); end
        end
        s_tvalid = 1'b1; s_tdata = 128'hBEEF;
        step();
        s_tvalid = 1'b0;
        n_chk++; if (level !== 11'd1024 || m_tdata !== 128'h100 || s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_push_to_full level=%0d d=%h rdy=%b want 1024/100/0", level, m_tdata, s_tready); end
        // Full: push blocked, pop only.
        s_tvalid = 1'b1; s_tdata = 128'hF00D; m_tready = 1'b1;
        step();
        n_chk++; if (level !== 11'd1023 || overflow !== 1'b1 || m_tdata !== 128'h101) begin n_fail++; $display("FAIL bp_full_pushpop level=%0d ovf=%b d=%h want 1023/1/101", level, overflow, m_tdata); end
        // Level 1023: push and pop together.
        s_tdata = 128'hCAFE;
        step();
        s_tvalid = 1'b0; m_tready = 1'b0;
        n_chk++; if (level !== 11'd1023 || m_tdata !== 128'h102 || rdptr !== 10'd2) begin n_fail++; $display("FAIL bp_pushpop level=%0d d=%h rdptr=%0d want 1023/102/2", level, m_tdata, rdptr); end
    endtask

    task automatic test_flush();
        // Continue from the backpressure state: level 1023, rdptr 2, overflow set.
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_chk++; if (rdptr !== 10'd1 || level !== 11'd0 || overflow !== 1'b0 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL flush_wrap rdptr=%0d level=%0d ovf=%b v=%b want 1/0/0/0", rdptr, level, overflow, m_tvalid); end
        do_reset();
        push_n(42, 128'h2000);
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        m_tready = 1'b0;
        n_chk++; if (rdptr !== 10'd5 || level !== 11'd37) begin n_fail++; $display("FAIL flush_setup rdptr=%0d level=%0d want 5/37", rdptr, level); end
        flush = 1'b1; s_tvalid = 1'b1; s_tdata = 128'h7777; m_tready = 1'b1;
        step();
        flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        n_chk++; if (level !== 11'd0 || m_tvalid !== 1'b0 || m_tdata !== 128'h0) begin n_fail++; $display("FAIL flush_clear level=%0d v=%b d=%h want 0/0/0", level, m_tvalid, m_tdata); end
        n_chk++; if (rdptr !== 10'd42) begin n_fail++; $display("FAIL flush_rdptr got %0d want 42", rdptr); end
        n_chk++; if (overflow !== 1'b0 || s_tready !== 1'b1) begin n_fail++; $display("FAIL flush_flags ovf=%b rdy=%b want 0/1", overflow, s_tready); end
        s_tvalid = 1'b1; s_tdata = 128'h3333;
        step();
        s_tvalid = 1'b0;
        step();
        n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== 128'h3333) begin n_fail++; $display("FAIL flush_next_word v=%b d=%h want 1/3333", m_tvalid, m_tdata); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_n(200, 128'h5000);
        n_chk++; if (level !== 11'd200) begin n_fail++; $display("FAIL midrst_setup level=%0d want 200", level); end
        rst = 1'b1; s_tvalid = 1'b1; s_tdata = 128'h9999; m_tready = 1'b1;
        step();
        n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_s_tready got %b want 0", s_tready); end
        n_chk++; if (level !== 11'd0 || m_tvalid !== 1'b0 || m_tdata !== 128'h0 || rdptr !== 10'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs level=%0d v=%b d=%h rdptr=%0d ovf=%b want all 0", level, m_tvalid, m_tdata, rdptr, overflow); end
        rst = 1'b0; s_tdata = 128'hABCD;
        #1;
        n_chk++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_s_tready got %b want 1", s_tready); end
        step();
        s_tvalid = 1'b0;
        step();
        n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== 128'hABCD) begin n_fail++; $display("FAIL midrst_first_word v=%b d=%h want 1/abcd", m_tvalid, m_tdata); end
        m_tready = 1'b0;
    endtask

`ifdef ACCEL_INBUF_WATERMARK_EN
    task automatic test_watermark();
        do_reset();
        push_n(1007, 128'h0);
        n_chk++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL wm_below got %b want 0", almost_full); end
        push_n(1, 128'h0);
        n_chk++; if (almost_full !== 1'b1 || level !== 11'd1008) begin n_fail++; $display("FAIL wm_rise af=%b level=%0d want 1/1008", almost_full, level); end
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        n_chk++; if (almost_full !== 1'b0 || level !== 11'd1007) begin n_fail++; $display("FAIL wm_fall af=%b level=%0d want 0/1007", almost_full, level); end
    endtask
`endif

    task automatic test_stream();
        logic [127:0] q[$];
        logic [127:0] exp_w, w, pd;
        logic         pu, po;
        int sent, recv, maxlvl, bad;
        sent = 0; recv = 0; maxlvl = 0; bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 20000 && recv < 3000; cyc++) begin
            w = {32'(sent), ~32'(sent), 32'(sent) * 32'd3, 32'hA5A5_0000 ^ 32'(sent)};
            s_tvalid = (sent < 3000) && ($urandom_range(0, 99) < 70);
            s_tdata  = w;
            m_tready = ($urandom_range(0, 99) < 70);
            pu = s_tvalid && s_tready;
            po = m_tvalid && m_tready;
            pd = m_tdata;
            step();
            if (pu) begin q.push_back(w); sent++; end
            if (po) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL stream_extra_word got %h want none", pd);
                    bad++;
                end else begin
                    exp_w = q.pop_front();
                    if (pd !== exp_w) begin
                        n_fail++;
                        if (bad < 5) $display("FAIL stream_word[%0d] got %h want %h", recv, pd, exp_w);
                        bad++;
                    end
                end
                recv++;
            end
            if (int'(level) > maxlvl) maxlvl = int'(level);
            n_chk++;
            if (level !== 11'(q.size())) begin
                n_fail++;
                if (bad < 5) $display("FAIL stream_level got %0d want %0d", level, q.size());
                bad++;
            end
        end
        s_tvalid = 1'b0; m_tready = 1'b0;
        n_chk++; if (recv != 3000 || q.size() != 0) begin n_fail++; $display("FAIL stream_count got %0d words (%0d left) want 3000 (0)", recv, q.size()); end
        n_chk++; if (maxlvl > 1024) begin n_fail++; $display("FAIL stream_max_level got %0d want <=1024", maxlvl); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_flush();
        test_mid_reset();
`ifdef ACCEL_INBUF_WATERMARK_EN
        test_watermark();
`endif
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_inbuf.md
Name: accel_inbuf

Overview:
- Accelerator-side input buffer directly downstream of the AXI4 controller's to-accelerator stream.
- Accepts 128-bit command/operand words on the toaccel stream and holds them in a DEPTH-entry on-chip buffer.
- Presents the words in order to the ECDSA core through a registered valid/ready output.
- Returns a consumed-word read pointer (toaccel_rdptr) so the controller can track free space.

Parameters:
- DW, 128, data width in bits.
- DEPTH, 1024, number of buffer entries; power of two, minimum 4.
- AW, 10, log2(DEPTH); the pointer width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered words.
- s_tdata  in  DW  word from the controller (toaccel_tdata).
- s_tvalid  in  1  input word valid.
- s_tready  out  1  buffer can accept a word.
- rdptr  out  AW  count of words consumed by the core, mod DEPTH (drives toaccel_rdptr).
- m_tdata  out  DW  word to the ECDSA core.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  core accepts the word.
- level  out  AW+1  words accepted but not yet consumed, range 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (rst=1 at an edge): wr_ptr, rd_ptr, rdptr, level = 0; m_tvalid = 0; m_tdata = 0; overflow = 0; s_tready = 0 while rst is high. Buffer contents are don't-care.
- The first cycle after rst deasserts: s_tready = 1.
- Reset mid-transfer drops every in-flight word; no partial state survives.
- Storage: DEPTH×DW array plus a one-entry output register (OREG).
  - wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - level counts array entries plus OREG.
- Push: s_tvalid && s_tready at an edge writes s_tdata into mem[wr_ptr] and increments wr_ptr.
- s_tready = (level != DEPTH); it is combinational from registered level only and never depends on s_tvalid.
- Attempted push while full (s_tvalid=1, s_tready=0): overflow is set and held until rst or flush; the data is ignored.
- OREG load: if (OREG empty or m_tvalid && m_tready) and the array is non-empty, then at the edge OREG <= mem[rd_ptr] and rd_ptr increments.
- Latency: a word pushed at edge N into an empty buffer gives m_tvalid = 1 after edge N+1, with m_tdata equal to that word. There is no combinational s→m path.
- Throughput: 1 word/cycle sustained with both sides active; no bubbles while the array is non-empty.
- Pop: m_tvalid && m_tready at an edge.
  - rdptr increments (wraps DEPTH-1 → 0).
  - OREG either reloads in the same edge or goes empty (m_tvalid = 0).
- m_tdata is stable while m_tvalid=1 and m_tready=0.
- level update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop (including at level = DEPTH, where push is blocked, so only −1 applies).
- Pointer wrap: array full ⇔ wr_ptr and rd_ptr have equal low AW bits and different MSBs; array empty ⇔ the pointers are equal.
- Ordering: strict FIFO order across all wraps.
- flush=1 at an edge: same effect as reset, except s_tready stays 1. rdptr is NOT cleared; it advances by the number of discarded words (rdptr <= rdptr + level), so the controller's free-space accounting stays consistent.
- flush takes priority over a same-cycle push or pop; the pushed word is discarded.
- rst has priority over flush.

Optional Feature:
- Macro: ACCEL_INBUF_WATERMARK_EN.
- When defined:
  - Adds parameter AF_LEVEL (default DEPTH-16).
  - Adds output almost_full (1 bit), registered: 1 when the post-update level >= AF_LEVEL, else 0.
  - Reset value 0; cleared by flush.
- When undefined: neither the port nor the parameter exists; all other behaviour is identical.

Test Plan:
- Reset then single word: push 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 at edge N, m_tready=1 → m_tvalid high after N+1 with the same data; level 1→0; rdptr=1.
- Fill to full: m_tready=0, push 1024 incrementing words.
  - After the last push: s_tready=0, level=1024.
  - 1025th attempt sets overflow=1.
  - Then drain 1024 words in order 0..1023; rdptr wraps to 0.
- Streaming with wrap: 3000 words, s_tvalid and m_tready each randomly 70% → output sequence equals input; level never exceeds 1024; no dropped or duplicated words.
- Backpressure stability: m_tready=0 for 5 cycles with m_tvalid=1 → m_tdata unchanged; a simultaneous push at level=1023 leaves level=1024.
- Flush: level=37, rdptr=5, pulse flush with a same-cycle push → level=0, m_tvalid=0, rdptr=42, overflow=0, s_tready=1.
- Mid-stream reset: rst for 1 cycle at level=200 → all outputs at reset values, s_tready=0 during rst and 1 the next cycle; the next pushed word emerges first (with ACCEL_INBUF_WATERMARK_EN, AF_LEVEL=1008: almost_full rises at the 1008th push and falls at level 1007).
